chunked_addsub: RTL and testbench

Parametrised multi-cycle adder/subtractor. It processes a WIDTH-bit operand pair CHUNK bits per clock, rippling the carry through a register between chunks. The result, carry-out and signed-overflow flag are presented together with a one-cycle `done` pulse. It is the sequential successor to the combinational 5-bit ripple adder labs, and it trades latency for a short carry path so wide operands meet timing.

---
 rtl/chunked_addsub_if.sv | 25 ++
 rtl/chunked_addsub.sv | 118 +++++++++++
 tb/tb_chunked_addsub.sv | 234 +++++++++++++++++++++++
 3 files changed

// File: rtl/chunked_addsub_if.sv
// Request/result bundle for chunked_addsub: operands and control in, status and result out.
interface chunked_addsub_if #(
  parameter int WIDTH = 16
) ();
  logic             start;
  logic             sub;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] s;
  logic             cout;
  logic             ovf;

  modport master (
    output start, sub, a, b, cin,
    input  busy, done, s, cout, ovf
  );

  modport slave (
    input  start, sub, a, b, cin,
    output busy, done, s, cout, ovf
  );
endinterface

// File: rtl/chunked_addsub.sv
// Multi-cycle adder/subtractor: adds CHUNK bits per clock and ripples the carry
// through a register, so the combinational carry chain is only CHUNK bits long.
// Subtraction is a + ~b + ~cin; results are published only when the last chunk completes.
module chunked_addsub #(
  parameter int WIDTH = 16,
  parameter int CHUNK = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  chunked_addsub_if.slave bus
);

  localparam int N_CHUNKS = WIDTH / CHUNK;
  localparam int IDX_W    = (N_CHUNKS > 1) ? $clog2(N_CHUNKS) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_CHUNKS - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic [IDX_W-1:0] idx;
  logic [WIDTH-1:0] opa;
  logic [WIDTH-1:0] opb;
  logic [WIDTH-1:0] work;
  logic [WIDTH-1:0] work_nxt;
  logic             carry;
  logic [31:0]      shamt;
  logic [CHUNK-1:0] a_chunk;
  logic [CHUNK-1:0] b_chunk;
  logic [CHUNK:0]   sum;
  logic             msb_cin;
  logic             last;
  logic [WIDTH-1:0] s_q;
  logic             cout_q;
  logic             ovf_q;

  // State register; reset aborts any operation in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state: start is only honoured in IDLE, DONE always lasts exactly one cycle.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (bus.start) state_nxt = RUN;
      RUN:     if (last)      state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Status outputs decode straight from the state so reset clears them at once.
  always_comb begin
    bus.busy = (state == RUN);
    bus.done = (state == DONE);
  end

  // One chunk of the ripple: select chunk idx, add with the registered carry,
  // and merge the partial sum into a copy of the work register.
  always_comb begin
    shamt    = 32'(idx) * 32'(CHUNK);
    a_chunk  = CHUNK'(opa >> shamt);
    b_chunk  = CHUNK'(opb >> shamt);
    sum      = {1'b0, a_chunk} + {1'b0, b_chunk} + {{CHUNK{1'b0}}, carry};
    // carry into the chunk's top bit, recovered from its sum bit and operand bits
    msb_cin  = a_chunk[CHUNK-1] ^ b_chunk[CHUNK-1] ^ sum[CHUNK-1];
    last     = (idx == LAST_IDX);
    work_nxt = work;
    for (int k = 0; k < N_CHUNKS; k++) begin
      if (idx == IDX_W'(k)) work_nxt[k*CHUNK +: CHUNK] = sum[CHUNK-1:0];
    end
  end

  // Operand capture in IDLE, chunk accumulation in RUN, result publish on the last chunk.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      opa    <= '0;
      opb    <= '0;
      carry  <= 1'b0;
      idx    <= '0;
      work   <= '0;
      s_q    <= '0;
      cout_q <= 1'b0;
      ovf_q  <= 1'b0;
    end else begin
      if (state == IDLE && bus.start) begin
        opa   <= bus.a;
        opb   <= bus.sub ? ~bus.b : bus.b;
        carry <= bus.cin ^ bus.sub;
        idx   <= '0;
      end else if (state == RUN) begin
        work  <= work_nxt;
        carry <= sum[CHUNK];
        if (last) begin
          s_q    <= work_nxt;
          cout_q <= sum[CHUNK];
          ovf_q  <= msb_cin ^ sum[CHUNK];
        end else begin
          idx <= idx + IDX_W'(1);
        end
      end
    end
  end

  assign bus.s    = s_q;
  assign bus.cout = cout_q;
  assign bus.ovf  = ovf_q;

endmodule

// File: tb/tb_chunked_addsub.sv
// Bench for chunked_addsub: a 16/4 instance and a 5/1 instance, directed cases
// plus random operations compared against an arithmetic reference model.
module tb_chunked_addsub;

  logic clk;
  logic rst16_n;
  logic rst5_n;

  int n_checks;
  int n_errors;

  longint unsigned last16;
  longint unsigned last5;

  chunked_addsub_if #(.WIDTH(16)) bus16 ();
  chunked_addsub_if #(.WIDTH(5))  bus5 ();

  chunked_addsub #(.WIDTH(16), .CHUNK(4)) dut16 (
    .clk   (clk),
    .rst_n (rst16_n),
    .bus   (bus16.slave)
  );

  chunked_addsub #(.WIDTH(5), .CHUNK(1)) dut5 (
    .clk   (clk),
    .rst_n (rst5_n),
    .bus   (bus5.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // comparison helper
  task automatic chk(input string tag, input longint unsigned got, input longint unsigned exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // reference: plain integer arithmetic on unsigned and signed interpretations
  function automatic void model(input int w, input longint unsigned a, input longint unsigned b,
                                input bit cin, input bit sub,
                                output longint unsigned s, output bit cout, output bit ovf);
    longint unsigned m;
    longint          one;
    longint          sa;
    longint          sb;
    longint          r;
    longint          hi;
    longint          lo;
    one = 1;
    m   = longint'((one << w) - 1);
    sa  = (((a >> (w - 1)) & 1) != 0) ? longint'(a) - (one << w) : longint'(a);
    sb  = (((b >> (w - 1)) & 1) != 0) ? longint'(b) - (one << w) : longint'(b);
    if (!sub) begin
      s    = (a + b + cin) & m;
      cout = ((a + b + cin) > m);
      r    = sa + sb + longint'(cin);
    end else begin
      s    = (a - b - cin) & m;
      cout = (a >= b + cin);
      r    = sa - sb - longint'(cin);
    end
    hi  = (one << (w - 1)) - 1;
    lo  = -(one << (w - 1));
    ovf = (r > hi) || (r < lo);
  endfunction

  task automatic set_in(input int w, input bit st, input bit sb, input longint unsigned a,
                        input longint unsigned b, input bit ci);
    if (w == 16) begin
      bus16.start = st; bus16.sub = sb; bus16.a = 16'(a); bus16.b = 16'(b); bus16.cin = ci;
    end else begin
      bus5.start = st; bus5.sub = sb; bus5.a = 5'(a); bus5.b = 5'(b); bus5.cin = ci;
    end
  endtask

  function automatic bit get_busy(input int w);
    return (w == 16) ? bus16.busy : bus5.busy;
  endfunction
  function automatic bit get_done(input int w);
    return (w == 16) ? bus16.done : bus5.done;
  endfunction
  function automatic longint unsigned get_s(input int w);
    return (w == 16) ? longint'(bus16.s) : longint'(bus5.s);
  endfunction
  function automatic bit get_cout(input int w);
    return (w == 16) ? bus16.cout : bus5.cout;
  endfunction
  function automatic bit get_ovf(input int w);
    return (w == 16) ? bus16.ovf : bus5.ovf;
  endfunction

  // Runs one operation; called at #1 after a rising edge. With spam set, start
  // stays high with a=1/b=1 throughout RUN and DONE.
  task automatic do_op(input int w, input longint unsigned a, input longint unsigned b,
                       input bit cin, input bit sub, input bit spam);
    longint unsigned es;
    bit              ec;
    bit              eo;
    longint unsigned prev;
    longint unsigned hold_val;
    int              n;
    int              cyc;
    int              busy_cnt;
    int              both_cnt;
    int              extra_done;
    n    = (w == 16) ? 4 : 5;
    prev = (w == 16) ? last16 : last5;
    model(w, a, b, cin, sub, es, ec, eo);
    set_in(w, 1'b1, sub, a, b, cin);
    @(posedge clk); #1;
    if (spam) set_in(w, 1'b1, 1'b0, 1, 1, 1'b0);
    else      set_in(w, 1'b0, 1'b0, 0, 0, 1'b0);
    cyc = 0; busy_cnt = 0; both_cnt = 0; hold_val = prev;
    while (!get_done(w) && cyc < 40) begin
      if (get_busy(w)) busy_cnt++;
      if (get_s(w) != prev) hold_val = get_s(w);
      @(posedge clk); #1;
      cyc++;
    end
    chk("latency", longint'(cyc), longint'(n));
    chk("busy_cycles", longint'(busy_cnt), longint'(n));
    chk("s_hold", hold_val, prev);
    chk("busy_with_done", longint'(get_busy(w)), 0);
    chk("s", get_s(w), es);
    chk("cout", longint'(get_cout(w)), longint'(ec));
    chk("ovf", longint'(get_ovf(w)), longint'(eo));
    if (w == 16) last16 = es; else last5 = es;
    @(posedge clk); #1;
    if (spam) set_in(w, 1'b0, 1'b0, 0, 0, 1'b0);
    chk("done_pulse_width", longint'(get_done(w)), 0);
    if (spam) begin
      extra_done = 0;
      for (int i = 0; i < 2 * n + 2; i++) begin
        if (get_done(w)) extra_done++;
        if (get_busy(w)) both_cnt++;
        @(posedge clk); #1;
      end
      chk("spam_extra_done", longint'(extra_done), 0);
      chk("spam_no_restart", longint'(both_cnt), 0);
      chk("spam_s", get_s(w), es);
    end
  endtask

  initial begin
    int              dn;
    longint unsigned ra;
    longint unsigned rb;
    n_checks = 0;
    n_errors = 0;
    last16   = 0;
    last5    = 0;
    rst16_n  = 1'b0;
    rst5_n   = 1'b0;
    set_in(16, 1'b0, 1'b0, 0, 0, 1'b0);
    set_in(5, 1'b0, 1'b0, 0, 0, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    chk("rst_busy16", longint'(bus16.busy), 0);
    chk("rst_done16", longint'(bus16.done), 0);
    chk("rst_s16", longint'(bus16.s), 0);
    chk("rst_cout16", longint'(bus16.cout), 0);
    chk("rst_ovf16", longint'(bus16.ovf), 0);
    chk("rst_busy5", longint'(bus5.busy), 0);
    chk("rst_s5", longint'(bus5.s), 0);
    @(negedge clk);
    rst16_n = 1'b1;
    rst5_n  = 1'b1;
    @(posedge clk); #1;

    // directed 16-bit cases
    do_op(16, 'h1234, 'h0FFF, 1'b0, 1'b0, 1'b0);
    chk("add_s_const", longint'(bus16.s), 'h2233);
    do_op(16, 'hFFFF, 'h0001, 1'b0, 1'b0, 1'b0);
    chk("ripple_cout_const", longint'(bus16.cout), 1);
    do_op(16, 'h7FFF, 'h0001, 1'b0, 1'b0, 1'b0);
    chk("ripple_ovf_const", longint'(bus16.ovf), 1);
    do_op(16, 'h0005, 'h0007, 1'b0, 1'b1, 1'b0);
    chk("sub_s_const", longint'(bus16.s), 'hFFFE);
    do_op(16, 'h8000, 'h0000, 1'b1, 1'b1, 1'b0);
    chk("sub_ovf_const", longint'(bus16.ovf), 1);

    // start held through RUN and DONE
    do_op(16, 'h2222, 'h1111, 1'b0, 1'b0, 1'b1);

    // reset two cycles into a run
    set_in(16, 1'b1, 1'b0, 'h1234, 'h0FFF, 1'b0);
    @(posedge clk); #1;
    set_in(16, 1'b0, 1'b0, 0, 0, 1'b0);
    @(posedge clk);
    @(posedge clk); #1;
    rst16_n = 1'b0;
    #1;
    chk("midrst_busy", longint'(bus16.busy), 0);
    chk("midrst_done", longint'(bus16.done), 0);
    chk("midrst_s", longint'(bus16.s), 0);
    chk("midrst_cout", longint'(bus16.cout), 0);
    chk("midrst_ovf", longint'(bus16.ovf), 0);
    last16 = 0;
    @(negedge clk);
    rst16_n = 1'b1;
    dn = 0;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      if (bus16.done) dn++;
    end
    chk("midrst_no_done", longint'(dn), 0);
    do_op(16, 'h1234, 'h0FFF, 1'b0, 1'b0, 1'b0);

    // random 16-bit
    for (int i = 0; i < 25; i++) begin
      ra = longint'($urandom_range(0, 'hFFFF));
      rb = longint'($urandom_range(0, 'hFFFF));
      do_op(16, ra, rb, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b0);
    end

    // 5-bit bit-serial
    do_op(5, 'b10001, 'b10101, 1'b0, 1'b0, 1'b0);
    chk("w5_s_const", longint'(bus5.s), 'b00110);
    for (int i = 0; i < 20; i++) begin
      ra = longint'($urandom_range(0, 31));
      rb = longint'($urandom_range(0, 31));
      do_op(5, ra, rb, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b0);
    end
    do_op(5, 'b00011, 'b00100, 1'b0, 1'b1, 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
